i2c_seq: RTL and testbench
==========================

I2C_SEQ -- requirements
Module: i2c_seq

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b1100101, the 7-bit target address used in every transaction.
REQ-002 SHALL have port sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester N has a transaction pending.
REQ-005 SHALL have ports req0_rw, req1_rw  input  1  0 = register write, 1 = register read.
REQ-006 SHALL have ports req0_reg, req1_reg, req0_wdata, req1_wdata  input  8  register index and write data.
REQ-007 SHALL have ports req0_ready, req1_ready  output  1  one-cycle pulse when the request is accepted.
REQ-008 SHALL have ports done  output  1, done_id  output  1, err  output  1, rdata  output  8  completion report.
REQ-009 SHALL have ports cmd_valid  output  1, cmd_op  output  3, cmd_byte  output  8, cmd_ready  input  1  byte-engine command channel.
REQ-010 SHALL have ports rsp_valid  input  1, rsp_nack  input  1, rsp_byte  input  8  byte-engine response channel.

Function
REQ-011 SHALL encode cmd_op as START=0, WRITE=1, READ=2, RESTART=3, STOP=4.
REQ-012 SHALL implement states IDLE, START, ADDR_W, REG, DATA, RSTART, ADDR_R, RD, STOP, DONE.
REQ-013 SHALL arbitrate round-robin in IDLE: with both valid, grant the requester not granted last; after reset, requester 0 has priority.
REQ-014 SHALL pulse reqN_ready in the cycle IDLE exits, and latch rw, reg, wdata and the grant id in that cycle.
REQ-015 SHALL issue exactly one command per state; cmd_valid stays high with cmd_op/cmd_byte stable until cmd_valid and cmd_ready are both high.
REQ-016 SHALL, after acceptance, drop cmd_valid and wait for rsp_valid before moving on; only one command outstanding.
REQ-017 SHALL sequence writes as START, ADDR_W ({SLAVE_ADDR,1'b0}), REG, DATA (wdata), STOP, DONE.
REQ-018 SHALL sequence reads as START, ADDR_W, REG, RSTART, ADDR_R ({SLAVE_ADDR,1'b1}), RD (cmd_byte=0, engine NACKs master side), STOP, DONE.
REQ-019 SHALL, on rsp_nack=1 after any WRITE, set a sticky error flag and go directly to STOP.
REQ-020 SHALL capture rsp_byte into rdata on the RD response; rdata holds until the next read completes.
REQ-021 SHALL pulse done for one cycle in DONE with done_id=grant id and err=sticky flag, then return to IDLE; err is valid only while done=1.
REQ-022 SHALL ignore rsp_valid when no command is outstanding.
REQ-023 SHALL sample requests that arrive during a transaction only on the next IDLE cycle; the next grant comes no earlier than the cycle after DONE.

Reset
REQ-024 SHALL, while sys_rst=0, force state IDLE, cmd_valid=0, cmd_op=0, cmd_byte=0, req0_ready=req1_ready=0, done=0, done_id=0, err=0, rdata=0, last-grant=1.
REQ-025 SHALL abandon any transaction in progress on reset, issue no STOP, and start from IDLE after release.

Configuration
REQ-026 SHALL support macro I2C_SEQ_RETRY_EN: when defined, a NACK on the first ADDR_W goes to RSTART and retries ADDR_W once; a second NACK takes REQ-019.
REQ-027 SHALL, without I2C_SEQ_RETRY_EN, treat every NACK per REQ-019 and generate no retry logic.

Verification
REQ-028 SHALL test: req0 write reg=0x10 wdata=0xA5, engine always ACK -> ops 0,1(0xCA),1(0x10),1(0xA5),4; done=1, done_id=0, err=0.
REQ-029 SHALL test: req1 read reg=0x22, engine returns 0x5C -> ops 0,1(0xCA),1(0x22),3,1(0xCB),2,4; rdata=0x5C, done_id=1.
REQ-030 SHALL test: req0 and req1 valid in the same cycle, both held -> grants 0 then 1, each with a one-cycle ready pulse.
REQ-031 SHALL test: NACK on the REG byte -> next op 4 (STOP); done with err=1; no DATA command issued.
REQ-032 SHALL test: cmd_ready held low 5 cycles -> cmd_valid, cmd_op and cmd_byte stay constant throughout.
REQ-033 SHALL test: sys_rst asserted mid-DATA -> all outputs at reset values immediately; next request starts cleanly with START; with I2C_SEQ_RETRY_EN, one address NACK -> ops 3, 1(0xCA) retry, err=0.

Source files
------------

// File: rtl/i2c_seq.sv
// i2c_seq: two-requester register read/write sequencer driving a byte-level I2C engine.
// Optional feature: define I2C_SEQ_RETRY_EN to retry a NACKed first address byte once.
module i2c_seq #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1100101
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic       req0_rw,
  input  logic       req1_rw,
  input  logic [7:0] req0_reg,
  input  logic [7:0] req1_reg,
  input  logic [7:0] req0_wdata,
  input  logic [7:0] req1_wdata,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       done,
  output logic       done_id,
  output logic       err,
  output logic [7:0] rdata,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  output logic [7:0] cmd_byte,
  input  logic       cmd_ready,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  input  logic [7:0] rsp_byte
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, REG, DATA, RSTART, ADDR_R, RD, STOP, DONE
  } state_t;

  localparam logic [2:0] OP_START   = 3'd0;
  localparam logic [2:0] OP_WRITE   = 3'd1;
  localparam logic [2:0] OP_READ    = 3'd2;
  localparam logic [2:0] OP_RESTART = 3'd3;
  localparam logic [2:0] OP_STOP    = 3'd4;

  state_t     state, state_n;
  logic       pending, pending_n;
  logic       last_grant, last_grant_n;
  logic       grant_id, grant_id_n;
  logic       rw_q, rw_n;
  logic [7:0] reg_q, reg_n;
  logic [7:0] wdata_q, wdata_n;
  logic [7:0] rdata_q, rdata_n;
  logic       err_q, err_n;
  logic       pick;
`ifdef I2C_SEQ_RETRY_EN
  logic       retried_q, retried_n;
  logic       retry_q, retry_n;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      rw_q       <= 1'b0;
      reg_q      <= 8'h00;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      retried_q  <= 1'b0;
      retry_q    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      last_grant <= last_grant_n;
      grant_id   <= grant_id_n;
      rw_q       <= rw_n;
      reg_q      <= reg_n;
      wdata_q    <= wdata_n;
      rdata_q    <= rdata_n;
      err_q      <= err_n;
`ifdef I2C_SEQ_RETRY_EN
      retried_q  <= retried_n;
      retry_q    <= retry_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    pending_n    = pending;
    last_grant_n = last_grant;
    grant_id_n   = grant_id;
    rw_n         = rw_q;
    reg_n        = reg_q;
    wdata_n      = wdata_q;
    rdata_n      = rdata_q;
    err_n        = err_q;
`ifdef I2C_SEQ_RETRY_EN
    retried_n    = retried_q;
    retry_n      = retry_q;
`endif
    pick         = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    done         = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = OP_START;
    cmd_byte     = 8'h00;

    // Grant gated by reset so ready cannot pulse while the block is held in reset.
    case (state)
      IDLE: begin
        if (sys_rst && (req0_valid || req1_valid)) begin
          pick         = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
          req0_ready   = ~pick;
          req1_ready   = pick;
          grant_id_n   = pick;
          last_grant_n = pick;
          rw_n         = pick ? req1_rw : req0_rw;
          reg_n        = pick ? req1_reg : req0_reg;
          wdata_n      = pick ? req1_wdata : req0_wdata;
          err_n        = 1'b0;
          pending_n    = 1'b0;
          state_n      = START;
`ifdef I2C_SEQ_RETRY_EN
          retried_n    = 1'b0;
          retry_n      = 1'b0;
`endif
        end
      end
      START:  cmd_op = OP_START;
      ADDR_W: begin cmd_op = OP_WRITE; cmd_byte = {SLAVE_ADDR, 1'b0}; end
      REG:    begin cmd_op = OP_WRITE; cmd_byte = reg_q;              end
      DATA:   begin cmd_op = OP_WRITE; cmd_byte = wdata_q;            end
      RSTART: cmd_op = OP_RESTART;
      ADDR_R: begin cmd_op = OP_WRITE; cmd_byte = {SLAVE_ADDR, 1'b1}; end
      RD:     cmd_op = OP_READ;
      STOP:   cmd_op = OP_STOP;
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Each command state issues once, then waits for the engine's single response.
    if (state != IDLE && state != DONE) begin
      cmd_valid = ~pending;
      if (!pending) begin
        if (cmd_ready) pending_n = 1'b1;
      end else if (rsp_valid) begin
        pending_n = 1'b0;
        case (state)
          START: state_n = ADDR_W;
          ADDR_W: begin
            if (rsp_nack) begin
`ifdef I2C_SEQ_RETRY_EN
              if (!retried_q) begin
                retried_n = 1'b1;
                retry_n   = 1'b1;
                state_n   = RSTART;
              end else begin
                err_n   = 1'b1;
                state_n = STOP;
              end
`else
              err_n   = 1'b1;
              state_n = STOP;
`endif
            end else begin
              state_n = REG;
            end
          end
          REG: begin
            if (rsp_nack) begin
              err_n   = 1'b1;
              state_n = STOP;
            end else begin
              state_n = rw_q ? RSTART : DATA;
            end
          end
          DATA: begin
            if (rsp_nack) err_n = 1'b1;
            state_n = STOP;
          end
          RSTART: begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_q) begin
              retry_n = 1'b0;
              state_n = ADDR_W;
            end else begin
              state_n = ADDR_R;
            end
`else
            state_n = ADDR_R;
`endif
          end
          ADDR_R: begin
            if (rsp_nack) begin
              err_n   = 1'b1;
              state_n = STOP;
            end else begin
              state_n = RD;
            end
          end
          RD: begin
            rdata_n = rsp_byte;
            state_n = STOP;
          end
          STOP:    state_n = DONE;
          default: state_n = IDLE;
        endcase
      end
    end
  end

  assign done_id = grant_id;
  assign err     = done & err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_seq.sv
// tb_i2c_seq: table-driven and randomized check of i2c_seq against a queue-based transaction model.
// Build with +define+I2C_SEQ_RETRY_EN to exercise the address retry expectations.
module tb_i2c_seq;

  localparam logic [6:0] SLAVE = 7'b1100101;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_rw = 1'b0, req1_rw = 1'b0;
  logic [7:0] req0_reg = 8'h00, req1_reg = 8'h00;
  logic [7:0] req0_wdata = 8'h00, req1_wdata = 8'h00;
  logic       req0_ready, req1_ready;
  logic       done, done_id, err;
  logic [7:0] rdata;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_byte;
  logic       cmd_ready = 1'b0;
  logic       rsp_valid = 1'b0, rsp_nack = 1'b0;
  logic [7:0] rsp_byte = 8'h00;

  i2c_seq dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_rw(req0_rw), .req1_rw(req1_rw),
    .req0_reg(req0_reg), .req1_reg(req1_reg),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .done(done), .done_id(done_id), .err(err), .rdata(rdata),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_byte(rsp_byte)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          id;
    bit          rw;
    logic [7:0]  rg, wd, rb;
    logic [15:0] nack;
    int          dly;
    int          abort_at;
    bit          both;
  } txn_t;

  typedef struct {
    txn_t        t;
    int          exp_n;
    logic [10:0] exp_seq [8];
    bit          exp_err;
    logic [7:0]  exp_rdata;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [10:0] obs_q [$];
  logic [10:0] exp_q [$];
  bit          exp_err, exp_read;
  logic        obs_done_id, obs_err;
  logic [7:0]  obs_rdata;
  logic [7:0]  model_rdata = 8'h00;
  vec_t        vt [7];
  txn_t        r;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic txn_t mk_txn(input bit id, input bit rw, input logic [7:0] rg,
                                  input logic [7:0] wd, input logic [7:0] rb,
                                  input logic [15:0] nack, input int dly);
    txn_t t;
    t.id = id; t.rw = rw; t.rg = rg; t.wd = wd; t.rb = rb;
    t.nack = nack; t.dly = dly; t.abort_at = -1; t.both = 1'b0;
    return t;
  endfunction

  // Reference: the nominal command list, cut short at a NACKed write (or retried once on the first address).
  task automatic build_model(input txn_t t);
    logic [10:0] base [$];
    int p, i;
    bit retried;
    exp_q.delete();
    exp_err = 1'b0;
    exp_read = 1'b0;
    base.push_back(11'h000);
    base.push_back({3'd1, SLAVE, 1'b0});
    base.push_back({3'd1, t.rg});
    if (t.rw) begin
      base.push_back(11'h300);
      base.push_back({3'd1, SLAVE, 1'b1});
      base.push_back(11'h200);
    end else begin
      base.push_back({3'd1, t.wd});
    end
    base.push_back(11'h400);
    p = 0; i = 0; retried = 1'b0;
    while (p < base.size()) begin
      exp_q.push_back(base[p]);
      if (base[p][10:8] == 3'd1 && t.nack[i]) begin
        i++;
`ifdef I2C_SEQ_RETRY_EN
        if (p == 1 && !retried) begin
          retried = 1'b1;
          exp_q.push_back(11'h300);
          i++;
          continue;
        end
`endif
        exp_err = 1'b1;
        exp_q.push_back(11'h400);
        break;
      end
      if (base[p][10:8] == 3'd2) exp_read = 1'b1;
      i++;
      p++;
    end
  endtask

  // Request, then play the byte engine until done, optionally stalling cmd_ready or resetting mid-flight.
  task automatic applyStimulus(input txn_t t);
    bit got, fin, stray;
    int i, phase, hold;
    logic [11:0] first_cmd;
    logic [2:0]  cur_op;
    obs_q.delete();
    obs_done_id = 1'b0; obs_err = 1'b0; obs_rdata = 8'h00;
    if (t.id || t.both) begin
      req1_valid = 1'b1;
      req1_rw    = t.both ? 1'b0  : t.rw;
      req1_reg   = t.both ? 8'h5A : t.rg;
      req1_wdata = t.both ? 8'h3C : t.wd;
    end
    if (!t.id) begin
      req0_valid = 1'b1; req0_rw = t.rw; req0_reg = t.rg; req0_wdata = t.wd;
    end
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        checkOutput("ready_id", {req1_ready, req0_ready}, t.id ? 2'b10 : 2'b01);
      end
      @(negedge sys_clk);
    end
    if (!got) begin
      checkOutput("ready_timeout", 0, 1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    #1;
    checkOutput("ready_pulse", {req1_ready, req0_ready}, 2'b00);
    if (t.id) req1_valid = 1'b0; else req0_valid = 1'b0;
    i = 0; phase = 0; hold = 0; fin = 1'b0; stray = 1'b0; first_cmd = '0; cur_op = 3'd0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (req0_ready || req1_ready) stray = 1'b1;
      if (done) begin
        fin = 1'b1;
        obs_done_id = done_id; obs_err = err; obs_rdata = rdata;
      end else begin
        case (phase)
          0: if (cmd_valid) begin
            if (i == t.abort_at) begin
              sys_rst = 1'b0;
              #1;
              checkOutput("rst_outputs", {cmd_valid, cmd_op, cmd_byte, req0_ready, req1_ready,
                                          done, done_id, err, rdata}, 0);
              @(negedge sys_clk);
              #1;
              checkOutput("rst_held", {cmd_valid, cmd_op, cmd_byte, done, rdata}, 0);
              sys_rst = 1'b1;
              return;
            end else if (hold < t.dly) begin
              if (hold == 0) first_cmd = {cmd_valid, cmd_op, cmd_byte};
              else checkOutput("cmd_stable", {cmd_valid, cmd_op, cmd_byte}, first_cmd);
              rsp_valid = 1'b1; rsp_nack = 1'b1; rsp_byte = 8'($urandom);
              hold++;
            end else begin
              if (t.dly > 0) checkOutput("cmd_stable", {cmd_valid, cmd_op, cmd_byte}, first_cmd);
              rsp_valid = 1'b0; rsp_nack = 1'b0;
              cmd_ready = 1'b1;
              obs_q.push_back({cmd_op, cmd_byte});
              cur_op = cmd_op;
              phase = 1;
            end
          end
          1: begin
            cmd_ready = 1'b0;
            checkOutput("cmd_drop", cmd_valid, 0);
            rsp_valid = 1'b1;
            rsp_nack  = (cur_op == 3'd1) ? t.nack[i] : (cur_op == 3'd2);
            rsp_byte  = (cur_op == 3'd2) ? t.rb : 8'($urandom);
            i++;
            phase = 2;
          end
          default: begin
            rsp_valid = 1'b0; rsp_nack = 1'b0;
            hold = 0;
            phase = 0;
          end
        endcase
      end
      @(negedge sys_clk);
      #1;
    end
    if (!fin) begin
      checkOutput("txn_timeout", 0, 1);
      cmd_ready = 1'b0; rsp_valid = 1'b0;
      return;
    end
    checkOutput("done_pulse", done, 0);
    checkOutput("stray_ready", stray, 0);
  endtask

  task automatic compareTxn(input txn_t t);
    build_model(t);
    if (exp_read) model_rdata = t.rb;
    checkOutput("seq_len", obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      checkOutput("seq_op", (k < obs_q.size()) ? {21'd0, obs_q[k]} : 32'hFFFF_FFFF, exp_q[k]);
    checkOutput("done_id", obs_done_id, t.id);
    checkOutput("err", obs_err, exp_err);
    checkOutput("rdata", obs_rdata, model_rdata);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vt[0].t = mk_txn(0, 0, 8'h10, 8'hA5, 8'h00, 16'h0000, 0);
    vt[0].exp_n = 5; vt[0].exp_err = 0; vt[0].exp_rdata = 8'h00;
    vt[0].exp_seq = '{11'h000, 11'h1CA, 11'h110, 11'h1A5, 11'h400, 11'h0, 11'h0, 11'h0};
    vt[1].t = mk_txn(1, 1, 8'h22, 8'h00, 8'h5C, 16'h0000, 0);
    vt[1].exp_n = 7; vt[1].exp_err = 0; vt[1].exp_rdata = 8'h5C;
    vt[1].exp_seq = '{11'h000, 11'h1CA, 11'h122, 11'h300, 11'h1CB, 11'h200, 11'h400, 11'h0};
    vt[2].t = mk_txn(0, 0, 8'h33, 8'h77, 8'h00, 16'h0004, 1);
    vt[2].exp_n = 4; vt[2].exp_err = 1; vt[2].exp_rdata = 8'h5C;
    vt[2].exp_seq = '{11'h000, 11'h1CA, 11'h133, 11'h400, 11'h0, 11'h0, 11'h0, 11'h0};
    vt[3].t = mk_txn(1, 0, 8'h44, 8'h99, 8'h00, 16'h0000, 5);
    vt[3].exp_n = 5; vt[3].exp_err = 0; vt[3].exp_rdata = 8'h5C;
    vt[3].exp_seq = '{11'h000, 11'h1CA, 11'h144, 11'h199, 11'h400, 11'h0, 11'h0, 11'h0};
    vt[4].t = mk_txn(0, 1, 8'h55, 8'h00, 8'h11, 16'h0010, 2);
    vt[4].exp_n = 6; vt[4].exp_err = 1; vt[4].exp_rdata = 8'h5C;
    vt[4].exp_seq = '{11'h000, 11'h1CA, 11'h155, 11'h300, 11'h1CB, 11'h400, 11'h0, 11'h0};
    vt[5].t = mk_txn(1, 0, 8'h66, 8'h12, 8'h00, 16'h0002, 0);
    vt[6].t = mk_txn(0, 0, 8'h67, 8'h13, 8'h00, 16'h000A, 0);
`ifdef I2C_SEQ_RETRY_EN
    vt[5].exp_n = 7; vt[5].exp_err = 0; vt[5].exp_rdata = 8'h5C;
    vt[5].exp_seq = '{11'h000, 11'h1CA, 11'h300, 11'h1CA, 11'h166, 11'h112, 11'h400, 11'h0};
    vt[6].exp_n = 5; vt[6].exp_err = 1; vt[6].exp_rdata = 8'h5C;
    vt[6].exp_seq = '{11'h000, 11'h1CA, 11'h300, 11'h1CA, 11'h400, 11'h0, 11'h0, 11'h0};
`else
    vt[5].exp_n = 3; vt[5].exp_err = 1; vt[5].exp_rdata = 8'h5C;
    vt[5].exp_seq = '{11'h000, 11'h1CA, 11'h400, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0};
    vt[6].exp_n = 3; vt[6].exp_err = 1; vt[6].exp_rdata = 8'h5C;
    vt[6].exp_seq = '{11'h000, 11'h1CA, 11'h400, 11'h0, 11'h0, 11'h0, 11'h0, 11'h0};
`endif

    repeat (3) @(negedge sys_clk);
    #1;
    checkOutput("reset_state", {cmd_valid, cmd_op, cmd_byte, req0_ready, req1_ready,
                                done, done_id, err, rdata}, 0);
    sys_rst = 1'b1;

    for (int k = 0; k < 7; k++) begin
      applyStimulus(vt[k].t);
      checkOutput("tbl_len", obs_q.size(), vt[k].exp_n);
      for (int j = 0; j < vt[k].exp_n; j++)
        checkOutput("tbl_op", (j < obs_q.size()) ? {21'd0, obs_q[j]} : 32'hFFFF_FFFF,
                    vt[k].exp_seq[j]);
      checkOutput("tbl_err", obs_err, vt[k].exp_err);
      checkOutput("tbl_rdata", obs_rdata, vt[k].exp_rdata);
      checkOutput("tbl_id", obs_done_id, vt[k].t.id);
      compareTxn(vt[k].t);
    end

    // Reset while the DATA byte is being offered; nothing further may be issued afterwards.
    r = mk_txn(1, 0, 8'h77, 8'h88, 8'h00, 16'h0000, 0);
    r.abort_at = 3;
    applyStimulus(r);
    model_rdata = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge sys_clk);
      #1;
      checkOutput("no_stop_after_rst", cmd_valid, 0);
    end

    // Both requesters valid together right after reset: requester 0 first, then 1.
    r = mk_txn(0, 0, 8'h01, 8'h02, 8'h00, 16'h0000, 0);
    r.both = 1'b1;
    applyStimulus(r);
    compareTxn(r);
    r = mk_txn(1, 0, 8'h5A, 8'h3C, 8'h00, 16'h0000, 0);
    applyStimulus(r);
    compareTxn(r);

    for (int n = 0; n < 40; n++) begin
      r = mk_txn(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 16'h0000, int'($urandom_range(3)));
      for (int b = 0; b < 16; b++) r.nack[b] = ($urandom_range(4) == 0);
      applyStimulus(r);
      compareTxn(r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
